// File: rtl/accum_block_looper.sv
// Source-side sequencer for the accumulation warp looper: walks every block
// offset of a block grid and, per block, every accumulation offset, one word per handshake.
module accum_block_looper #(
   parameter int unsigned WBW   = 16,
   parameter int unsigned VDIM  = 2,
   parameter int unsigned N_CFG = 4,
   localparam int unsigned NCFG_BW = $clog2(N_CFG + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          cfg_rdy,
   output logic                          cfg_ack,
   input  logic [VDIM-1:0][WBW-1:0]      i_bgrid_end,
   input  logic [VDIM-1:0][WBW-1:0]      i_bgrid_step,
   input  logic [VDIM-1:0][WBW-1:0]      i_abeg,
   input  logic [VDIM-1:0][WBW-1:0]      i_aend,
   input  logic [VDIM-1:0][WBW-1:0]      i_astep,
   input  logic [NCFG_BW-1:0]            i_id_beg,
   input  logic [NCFG_BW-1:0]            i_id_end,
   input  logic [NCFG_BW-1:0]            i_id_ret,
   output logic                          dst_rdy,
   input  logic                          dst_ack,
   output logic [VDIM-1:0][WBW-1:0]      o_bofs,
   output logic [VDIM-1:0][WBW-1:0]      o_aofs,
   output logic [VDIM-1:0][WBW-1:0]      o_alofs,
   output logic                          o_islast,
   output logic [NCFG_BW-1:0]            o_id_beg,
   output logic [NCFG_BW-1:0]            o_id_end,
   output logic [NCFG_BW-1:0]            o_id_ret
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t state, state_nxt;

   logic [VDIM-1:0][WBW-1:0] bend, bstep, abeg, aend, astep;
   logic [VDIM-1:0][WBW-1:0] bend_nxt, bstep_nxt, abeg_nxt, aend_nxt, astep_nxt;
   logic [VDIM-1:0][WBW-1:0] bofs_nxt, aofs_nxt, alofs_nxt;
   logic [NCFG_BW-1:0]       id_beg_nxt, id_end_nxt, id_ret_nxt;

   logic [VDIM-1:0][WBW:0]   a_sum, b_sum;
   logic [VDIM-1:0]          a_wrap, b_wrap;
   logic                     cfg_empty;
   logic                     carry;

   // One-bit-wider sums so a stride never wraps silently past the bound
   always_comb begin
      for (int d = 0; d < VDIM; d++) begin
         a_sum[d]  = {1'b0, o_aofs[d]} + {1'b0, astep[d]};
         b_sum[d]  = {1'b0, o_bofs[d]} + {1'b0, bstep[d]};
         a_wrap[d] = (a_sum[d] >= {1'b0, aend[d]});
         b_wrap[d] = (b_sum[d] >= {1'b0, bend[d]});
      end
   end

   always_comb begin
      cfg_empty = 1'b0;
      for (int d = 0; d < VDIM; d++) begin
         if ((i_bgrid_end[d] == '0) || (i_aend[d] <= i_abeg[d]))
            cfg_empty = 1'b1;
      end
   end

   assign o_islast = (state == RUN) && (&a_wrap) && (&b_wrap);

   // Next-state and datapath updates
   always_comb begin
      state_nxt  = state;
      cfg_ack    = 1'b0;
      bend_nxt   = bend;
      bstep_nxt  = bstep;
      abeg_nxt   = abeg;
      aend_nxt   = aend;
      astep_nxt  = astep;
      bofs_nxt   = o_bofs;
      aofs_nxt   = o_aofs;
      alofs_nxt  = o_alofs;
      id_beg_nxt = o_id_beg;
      id_end_nxt = o_id_end;
      id_ret_nxt = o_id_ret;
      carry      = 1'b1;

      case (state)
         IDLE: begin
            cfg_ack = cfg_rdy;
            if (cfg_rdy) begin
               bend_nxt   = i_bgrid_end;
               bstep_nxt  = i_bgrid_step;
               abeg_nxt   = i_abeg;
               aend_nxt   = i_aend;
               astep_nxt  = i_astep;
               bofs_nxt   = '0;
               aofs_nxt   = i_abeg;
               alofs_nxt  = '0;
               id_beg_nxt = i_id_beg;
               id_end_nxt = i_id_end;
               id_ret_nxt = i_id_ret;
               state_nxt  = cfg_empty ? IDLE : RUN;
            end
         end
         RUN: begin
            if (dst_ack) begin
               if (o_islast) begin
                  state_nxt = IDLE;
               end else begin
                  // Accumulation is the inner loop; highest dim steps fastest
                  for (int d = VDIM - 1; d >= 0; d--) begin
                     if (carry) begin
                        if (a_wrap[d]) begin
                           aofs_nxt[d]  = abeg[d];
                           alofs_nxt[d] = '0;
                        end else begin
                           aofs_nxt[d]  = a_sum[d][WBW-1:0];
                           alofs_nxt[d] = o_alofs[d] + astep[d];
                           carry        = 1'b0;
                        end
                     end
                  end
                  for (int d = VDIM - 1; d >= 0; d--) begin
                     if (carry) begin
                        if (b_wrap[d]) begin
                           bofs_nxt[d] = '0;
                        end else begin
                           bofs_nxt[d] = b_sum[d][WBW-1:0];
                           carry       = 1'b0;
                        end
                     end
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         dst_rdy  <= 1'b0;
         bend     <= '0;
         bstep    <= '0;
         abeg     <= '0;
         aend     <= '0;
         astep    <= '0;
         o_bofs   <= '0;
         o_aofs   <= '0;
         o_alofs  <= '0;
         o_id_beg <= '0;
         o_id_end <= '0;
         o_id_ret <= '0;
      end else begin
         dst_rdy  <= (state_nxt == RUN);
         bend     <= bend_nxt;
         bstep    <= bstep_nxt;
         abeg     <= abeg_nxt;
         aend     <= aend_nxt;
         astep    <= astep_nxt;
         o_bofs   <= bofs_nxt;
         o_aofs   <= aofs_nxt;
         o_alofs  <= alofs_nxt;
         o_id_beg <= id_beg_nxt;
         o_id_end <= id_end_nxt;
         o_id_ret <= id_ret_nxt;
      end
   end

endmodule
